// File: rtl/rvh_l1d_pkg.sv
// Shared types and helpers for the L1D request arbiter.
package rvh_l1d_pkg;

  localparam int LDU_OP_WIDTH = 3;
  localparam int STU_OP_WIDTH = 5;

  // Requester select; values double as bit positions in the one-hot grant.
  typedef enum logic [1:0] {
    REQ_LD  = 2'd0,
    REQ_ST  = 2'd1,
    REQ_PTW = 2'd2
  } req_sel_e;

  // LR, SC and all AMO flavours occupy store opcodes 7..28.
  function automatic logic is_atomic_stu_op(input logic [STU_OP_WIDTH-1:0] op);
    return (op >= STU_OP_WIDTH'(7)) && (op <= STU_OP_WIDTH'(28));
  endfunction

endpackage

// File: rtl/rvh_l1d_req_arb_sel.sv
// Combinational priority selector with store aging; produces a one-hot grant.
module rvh_l1d_req_arb_sel
  import rvh_l1d_pkg::*;
(
  input  logic       en,
  input  logic       aged,
  input  logic       ld_vld,
  input  logic       st_vld,
  input  logic       ptw_vld,
  output logic [2:0] gnt
);

  // Normal order PTW > load > store; an aged store jumps to the front.
  always_comb begin
    gnt = '0;
    if (en) begin
      if (aged && st_vld) begin
        gnt[REQ_ST] = 1'b1;
      end else if (ptw_vld) begin
        gnt[REQ_PTW] = 1'b1;
      end else if (ld_vld) begin
        gnt[REQ_LD] = 1'b1;
      end else if (st_vld) begin
        gnt[REQ_ST] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvh_l1d_req_arb.sv
// L1D request arbiter: load/store/PTW onto one registered request slot,
// with store anti-starvation aging and an atomic serialization lock.
module rvh_l1d_req_arb
  import rvh_l1d_pkg::*;
#(
  parameter int PADDR_W    = 56,
  parameter int XLEN       = 64,
  parameter int ID_W       = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_req_vld_i,
  output logic                    ld_req_rdy_o,
  input  logic [LDU_OP_WIDTH-1:0] ld_req_opcode_i,
  input  logic [PADDR_W-1:0]      ld_req_addr_i,
  input  logic [ID_W-1:0]         ld_req_id_i,
  input  logic                    st_req_vld_i,
  output logic                    st_req_rdy_o,
  input  logic [STU_OP_WIDTH-1:0] st_req_opcode_i,
  input  logic [PADDR_W-1:0]      st_req_addr_i,
  input  logic [XLEN-1:0]         st_req_data_i,
  input  logic [ID_W-1:0]         st_req_id_i,
  input  logic                    ptw_req_vld_i,
  output logic                    ptw_req_rdy_o,
  input  logic [PADDR_W-1:0]      ptw_req_addr_i,
  input  logic [ID_W-1:0]         ptw_req_id_i,
  output logic                    is_ld_req_vld_o,
  output logic                    is_st_req_vld_o,
  output logic                    is_ptw_req_vld_o,
  output logic [LDU_OP_WIDTH-1:0] l1d_ld_opcode_o,
  output logic [STU_OP_WIDTH-1:0] l1d_st_opcode_o,
  output logic [PADDR_W-1:0]      l1d_addr_o,
  output logic [XLEN-1:0]         l1d_data_o,
  output logic [ID_W-1:0]         l1d_id_o,
  input  logic                    l1d_req_rdy_i,
  input  logic                    amo_done_i,
  output logic                    amo_busy_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

  logic [2:0]              slot_kind;
  logic [LDU_OP_WIDTH-1:0] slot_ld_op;
  logic [STU_OP_WIDTH-1:0] slot_st_op;
  logic [PADDR_W-1:0]      slot_addr;
  logic [XLEN-1:0]         slot_data;
  logic [ID_W-1:0]         slot_id;
  logic                    amo_busy;
  logic [CNT_W-1:0]        starve_cnt;

  logic       slot_valid;
  logic       slot_load;
  logic       arb_en;
  logic       aged;
  logic [2:0] gnt;

  assign slot_valid = |slot_kind;
  assign slot_load  = ~slot_valid | l1d_req_rdy_i;
  // Reset gates the enable so no requester sees a ready in the reset cycle.
  assign arb_en     = slot_load & ~amo_busy & ~rst;
  assign aged       = (starve_cnt == STARVE_TOP);

  rvh_l1d_req_arb_sel u_sel (
    .en      (arb_en),
    .aged    (aged),
    .ld_vld  (ld_req_vld_i),
    .st_vld  (st_req_vld_i),
    .ptw_vld (ptw_req_vld_i),
    .gnt     (gnt)
  );

  assign ld_req_rdy_o  = gnt[REQ_LD];
  assign st_req_rdy_o  = gnt[REQ_ST];
  assign ptw_req_rdy_o = gnt[REQ_PTW];

  // Slot register: load winner (fields of other requesters zeroed) or empty out.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_kind  <= '0;
      slot_ld_op <= '0;
      slot_st_op <= '0;
      slot_addr  <= '0;
      slot_data  <= '0;
      slot_id    <= '0;
    end else if (slot_load) begin
      slot_kind  <= gnt;
      slot_ld_op <= gnt[REQ_LD] ? ld_req_opcode_i : '0;
      slot_st_op <= gnt[REQ_ST] ? st_req_opcode_i : '0;
      slot_data  <= gnt[REQ_ST] ? st_req_data_i   : '0;
      if (gnt[REQ_PTW]) begin
        slot_addr <= ptw_req_addr_i;
        slot_id   <= ptw_req_id_i;
      end else if (gnt[REQ_LD]) begin
        slot_addr <= ld_req_addr_i;
        slot_id   <= ld_req_id_i;
      end else if (gnt[REQ_ST]) begin
        slot_addr <= st_req_addr_i;
        slot_id   <= st_req_id_i;
      end else begin
        slot_addr <= '0;
        slot_id   <= '0;
      end
    end
  end

  // Store starvation counter: counts lost arbitration opportunities, saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (gnt[REQ_ST]) begin
      starve_cnt <= '0;
    end else if (st_req_vld_i && arb_en && (starve_cnt != STARVE_TOP)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Atomic lock: set by an LR/SC/AMO grant, released only by completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      amo_busy <= 1'b0;
    end else if (amo_busy && amo_done_i) begin
      amo_busy <= 1'b0;
    end else if (gnt[REQ_ST] && is_atomic_stu_op(st_req_opcode_i)) begin
      amo_busy <= 1'b1;
    end
  end

  assign is_ld_req_vld_o  = slot_kind[REQ_LD];
  assign is_st_req_vld_o  = slot_kind[REQ_ST];
  assign is_ptw_req_vld_o = slot_kind[REQ_PTW];
  assign l1d_ld_opcode_o  = slot_ld_op;
  assign l1d_st_opcode_o  = slot_st_op;
  assign l1d_addr_o       = slot_addr;
  assign l1d_data_o       = slot_data;
  assign l1d_id_o         = slot_id;
  assign amo_busy_o       = amo_busy;

endmodule

// File: tb/tb_rvh_l1d_req_arb.sv
// Directed bench for rvh_l1d_req_arb with a slot scoreboard.
module tb_rvh_l1d_req_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_vld, ld_rdy, st_vld, st_rdy, ptw_vld, ptw_rdy;
  logic [2:0]  ld_op;
  logic [4:0]  st_op;
  logic [55:0] ld_addr, st_addr, ptw_addr;
  logic [63:0] st_data;
  logic [3:0]  ld_id, st_id, ptw_id;
  logic        is_ld, is_st, is_ptw;
  logic [2:0]  o_ld_op;
  logic [4:0]  o_st_op;
  logic [55:0] o_addr;
  logic [63:0] o_data;
  logic [3:0]  o_id;
  logic        l1d_rdy, amo_done, amo_busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  kind;  // {ptw, st, ld}
    logic [2:0]  ld_op;
    logic [4:0]  st_op;
    logic [55:0] addr;
    logic [63:0] data;
    logic [3:0]  id;
  } exp_t;

  exp_t sb[$];

  rvh_l1d_req_arb dut (
    .clk(clk), .rst(rst),
    .ld_req_vld_i(ld_vld), .ld_req_rdy_o(ld_rdy), .ld_req_opcode_i(ld_op),
    .ld_req_addr_i(ld_addr), .ld_req_id_i(ld_id),
    .st_req_vld_i(st_vld), .st_req_rdy_o(st_rdy), .st_req_opcode_i(st_op),
    .st_req_addr_i(st_addr), .st_req_data_i(st_data), .st_req_id_i(st_id),
    .ptw_req_vld_i(ptw_vld), .ptw_req_rdy_o(ptw_rdy),
    .ptw_req_addr_i(ptw_addr), .ptw_req_id_i(ptw_id),
    .is_ld_req_vld_o(is_ld), .is_st_req_vld_o(is_st), .is_ptw_req_vld_o(is_ptw),
    .l1d_ld_opcode_o(o_ld_op), .l1d_st_opcode_o(o_st_op), .l1d_addr_o(o_addr),
    .l1d_data_o(o_data), .l1d_id_o(o_id), .l1d_req_rdy_i(l1d_rdy),
    .amo_done_i(amo_done), .amo_busy_o(amo_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [2:0] lop, input logic [4:0] sop,
                      input logic [55:0] addr, input logic [63:0] data, input logic [3:0] id);
    exp_t e;
    e.kind = kind; e.ld_op = lop; e.st_op = sop; e.addr = addr; e.data = data; e.id = id;
    sb.push_back(e);
  endtask

  task automatic push_ld();
    push(3'b001, ld_op, 5'd0, ld_addr, 64'd0, ld_id);
  endtask
  task automatic push_st();
    push(3'b010, 3'd0, st_op, st_addr, st_data, st_id);
  endtask
  task automatic push_ptw();
    push(3'b100, 3'd0, 5'd0, ptw_addr, 64'd0, ptw_id);
  endtask

  task automatic chk_rdy(input string tag, input logic l, input logic s, input logic p);
    check({tag, "_ld_rdy"}, 64'(ld_rdy), 64'(l));
    check({tag, "_st_rdy"}, 64'(st_rdy), 64'(s));
    check({tag, "_ptw_rdy"}, 64'(ptw_rdy), 64'(p));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every slot the L1D takes must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      check("onehot", 64'($countones({is_ptw, is_st, is_ld}) <= 1), 64'd1);
      if ((is_ld | is_st | is_ptw) && l1d_rdy) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("slot_kind", 64'({is_ptw, is_st, is_ld}), 64'(e.kind));
          check("slot_ld_op", 64'(o_ld_op), 64'(e.ld_op));
          check("slot_st_op", 64'(o_st_op), 64'(e.st_op));
          check("slot_addr", 64'(o_addr), 64'(e.addr));
          check("slot_data", o_data, e.data);
          check("slot_id", 64'(o_id), 64'(e.id));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    ld_vld = 0; st_vld = 0; ptw_vld = 0;
    ld_op = 0; st_op = 0; ld_addr = 0; st_addr = 0; ptw_addr = 0;
    st_data = 0; ld_id = 0; st_id = 0; ptw_id = 0;
    l1d_rdy = 1'b1; amo_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_is", 64'({is_ptw, is_st, is_ld}), 64'd0);
    check("rst_busy", 64'(amo_busy), 64'd0);
    check("rst_addr", 64'(o_addr), 64'd0);
    check("rst_data", o_data, 64'd0);
    nxt();

    // Single load, one-cycle latency
    ld_vld = 1; ld_op = 3'd0; ld_addr = 56'h1000; ld_id = 4'd3;
    @(negedge clk);
    chk_rdy("ld1", 1, 0, 0);
    push_ld();
    nxt();
    ld_vld = 0;
    @(negedge clk);
    check("ld1_is_ld", 64'(is_ld), 64'd1);
    check("ld1_st_op", 64'(o_st_op), 64'd0);
    nxt();

    // All three valid: PTW, then load, then store
    ptw_vld = 1; ptw_addr = 56'h2_0000; ptw_id = 4'd1;
    ld_vld = 1; ld_op = 3'd5; ld_addr = 56'h3040; ld_id = 4'd2;
    st_vld = 1; st_op = 5'd3; st_addr = 56'h5080; st_data = 64'hDEAD_BEEF_0123_4567; st_id = 4'd9;
    @(negedge clk); chk_rdy("pri1", 0, 0, 1); push_ptw(); nxt(); ptw_vld = 0;
    @(negedge clk); chk_rdy("pri2", 1, 0, 0); push_ld(); nxt(); ld_vld = 0;
    @(negedge clk); chk_rdy("pri3", 0, 1, 0); push_st(); nxt(); st_vld = 0;

    // Aging: store loses 8 times to a steady load, wins the 9th
    ld_vld = 1; ld_op = 3'd2; ld_addr = 56'h7000; ld_id = 4'd4;
    st_vld = 1; st_op = 5'd1; st_addr = 56'h8000; st_data = 64'h1111_2222_3333_4444; st_id = 4'd5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk_rdy($sformatf("age%0d", i), 1, 0, 0); push_ld(); nxt();
    end
    @(negedge clk);
    check("age_cnt_top", 64'(dut.starve_cnt), 64'd8);
    chk_rdy("age_win", 0, 1, 0); push_st(); nxt();
    @(negedge clk);
    check("age_cnt_clr", 64'(dut.starve_cnt), 64'd0);
    chk_rdy("age_after", 1, 0, 0); push_ld(); nxt();
    ld_vld = 0; st_vld = 0;

    // Atomic lock
    st_vld = 1; st_op = 5'd11; st_addr = 56'h9000; st_data = 64'hA5A5_A5A5_5A5A_5A5A; st_id = 4'd6;
    @(negedge clk); chk_rdy("amo_gnt", 0, 1, 0); push_st(); nxt();
    st_vld = 0;
    ld_vld = 1; ld_op = 3'd1; ld_addr = 56'hA000; ld_id = 4'd7;
    ptw_vld = 1; ptw_addr = 56'hB000; ptw_id = 4'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("amo_busy%0d", i), 64'(amo_busy), 64'd1);
      chk_rdy($sformatf("amo_hold%0d", i), 0, 0, 0);
      nxt();
    end
    ptw_vld = 0; amo_done = 1;
    @(negedge clk);
    check("amo_done_busy", 64'(amo_busy), 64'd1);
    chk_rdy("amo_done_cyc", 0, 0, 0);
    nxt();
    amo_done = 0;
    @(negedge clk);
    check("amo_released", 64'(amo_busy), 64'd0);
    chk_rdy("amo_resume", 1, 0, 0); push_ld(); nxt();
    ld_vld = 0;
    @(negedge clk); nxt();

    // Stall: slot holds a store while L1D is not ready
    l1d_rdy = 0;
    st_vld = 1; st_op = 5'd2; st_addr = 56'hC000; st_data = 64'h0F0F_F0F0_0F0F_F0F0; st_id = 4'd10;
    @(negedge clk); chk_rdy("stall_gnt", 0, 1, 0); push_st(); nxt();
    st_vld = 0;
    ld_vld = 1; ld_op = 3'd4; ld_addr = 56'hD000; ld_id = 4'd11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_rdy($sformatf("stall%0d", i), 0, 0, 0);
      check($sformatf("stall_is_st%0d", i), 64'(is_st), 64'd1);
      check($sformatf("stall_addr%0d", i), 64'(o_addr), 64'h0000_0000_00C0_00);
      check($sformatf("stall_data%0d", i), o_data, 64'h0F0F_F0F0_0F0F_F0F0);
      nxt();
    end
    l1d_rdy = 1;
    @(negedge clk); chk_rdy("stall_release", 1, 0, 0); push_ld(); nxt();
    ld_vld = 0;
    @(negedge clk); nxt();

    // Reset while slot valid and lock held
    l1d_rdy = 0;
    st_vld = 1; st_op = 5'd20; st_addr = 56'hE000; st_data = 64'h7777; st_id = 4'd12;
    @(negedge clk); chk_rdy("rst_amo_gnt", 0, 1, 0); nxt();
    st_vld = 0;
    @(negedge clk);
    check("pre_rst_is_st", 64'(is_st), 64'd1);
    check("pre_rst_busy", 64'(amo_busy), 64'd1);
    nxt();
    rst = 1;
    ld_vld = 1; ld_addr = 56'hF000; ld_id = 4'd13;
    st_vld = 1; st_op = 5'd3; st_addr = 56'hF100; st_data = 64'h55; st_id = 4'd14;
    ptw_vld = 1; ptw_addr = 56'hF200; ptw_id = 4'd15;
    @(negedge clk); chk_rdy("rst_cyc", 0, 0, 0); nxt();
    rst = 0; l1d_rdy = 1;
    @(negedge clk);
    check("post_rst_is", 64'({is_ptw, is_st, is_ld}), 64'd0);
    check("post_rst_busy", 64'(amo_busy), 64'd0);
    check("post_rst_addr", 64'(o_addr), 64'd0);
    check("post_rst_data", o_data, 64'd0);
    check("post_rst_st_op", 64'(o_st_op), 64'd0);
    chk_rdy("post_rst_gnt", 0, 0, 1); push_ptw(); nxt();
    ld_vld = 0; st_vld = 0; ptw_vld = 0;
    @(negedge clk); nxt();
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rvh_l1d_req_arb.md
Name: rvh_l1d_req_arb

Overview:
- Arbitrates three requesters (load pipe, store pipe, page-table walker) onto the single L1D request slot.
- The slot feeds the L1D request-type decoder: one-hot is_*_req_vld outputs plus opcodes.
- Output is registered through a one-entry valid/ready stage.
- Provides store anti-starvation aging and serializes atomic/LR/SC requests with a lock that holds until the L1D reports completion.

Parameters:
- PADDR_W, 56, physical address width.
- XLEN, 64, store data width.
- ID_W, 4, request tag width.
- STARVE_MAX, 8, consecutive lost-arbitration cycles after which the store gets top priority (must be ≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ld_req_vld_i  in  1  load request valid.
- ld_req_rdy_o  out  1  load request accepted this cycle.
- ld_req_opcode_i  in  3  LDU opcode (0..6).
- ld_req_addr_i  in  PADDR_W  load address.
- ld_req_id_i  in  ID_W  load tag.
- st_req_vld_i  in  1  store/AMO request valid.
- st_req_rdy_o  out  1  store request accepted.
- st_req_opcode_i  in  5  STU opcode (0..28).
- st_req_addr_i  in  PADDR_W  store address.
- st_req_data_i  in  XLEN  store/AMO operand.
- st_req_id_i  in  ID_W  store tag.
- ptw_req_vld_i  in  1  PTW request valid.
- ptw_req_rdy_o  out  1  PTW request accepted.
- ptw_req_addr_i  in  PADDR_W  PTW address.
- ptw_req_id_i  in  ID_W  PTW tag.
- is_ld_req_vld_o  out  1  slot holds a load.
- is_st_req_vld_o  out  1  slot holds a store.
- is_ptw_req_vld_o  out  1  slot holds a PTW request.
- l1d_ld_opcode_o  out  3  slot load opcode; 0 when the slot is not a load.
- l1d_st_opcode_o  out  5  slot store opcode; 0 when the slot is not a store.
- l1d_addr_o  out  PADDR_W  slot address.
- l1d_data_o  out  XLEN  slot data; 0 when the slot is not a store.
- l1d_id_o  out  ID_W  slot tag.
- l1d_req_rdy_i  in  1  L1D consumes the slot this cycle.
- amo_done_i  in  1  one-cycle pulse: the locked atomic has completed.
- amo_busy_o  out  1  atomic lock held.

Behaviour:
- Reset: all outputs 0, slot empty, lock clear, starvation count 0.
- Slot valid = OR of the is_*_req_vld_o outputs. At most one of them is high in any cycle.
- slot_load = ~slot_valid | l1d_req_rdy_i.
- A grant happens only when slot_load & ~amo_busy_o & some request is valid. The winner's rdy_o is high combinationally in that cycle; every other rdy_o is 0.
- Latency: request accepted in cycle N appears on the slot outputs in cycle N+1.
- Back-to-back acceptance is allowed when l1d_req_rdy_i is high every cycle.
- If the slot is consumed and there is no grant, the slot empties next cycle.
- If slot_valid & ~l1d_req_rdy_i, the slot contents are held stable and all rdy_o are 0.
- Priority, normal: PTW > load > store.
- Priority, aged: when starve_cnt == STARVE_MAX, store > PTW > load.
- starve_cnt increments when st_req_vld_i is high, the store is not granted, and slot_load & ~amo_busy_o holds. It saturates at STARVE_MAX and clears on a store grant.
- If st_req_vld_i drops while not granted, the count holds; it does not clear.
- Atomic lock: a store grant with opcode in 7..28 (LR, SC, AMO) sets amo_busy_o on the next cycle.
- While amo_busy_o is high, no grants occur, including loads and PTW. The slot still drains normally.
- amo_done_i while busy clears the lock at that edge. Grants resume the following cycle, never in the same cycle as amo_done_i.
- amo_done_i while not busy is ignored.
- Reset mid-operation: the slot is dropped, the lock clears, the count clears. No rdy_o is asserted in the reset cycle.
- Unused-field zeroing in the slot is performed at load time.

Decomposition:
- Shared package rvh_l1d_pkg:
  - LDU_OP_WIDTH=3, STU_OP_WIDTH=5.
  - Requester-select enum {REQ_LD, REQ_ST, REQ_PTW}.
  - is_atomic_stu_op() helper covering opcodes 7..28.
- One sub-module is natural: rvh_l1d_req_arb_sel, the combinational priority/aging selector producing a one-hot grant. The slot register, lock and counter stay in the top module.

Test Plan:
- Load op 0 at addr 0x1000, id 3, slot empty → ld_req_rdy_o=1 in cycle N; cycle N+1: is_ld_req_vld_o=1, l1d_ld_opcode_o=0, l1d_addr_o=0x1000, l1d_id_o=3, l1d_st_opcode_o=0.
- PTW, load and store all valid, l1d_req_rdy_i=1 → grant order PTW, load, store over three cycles. The is_* output changes one-hot every cycle.
- Load continuously valid, store valid, STARVE_MAX=8 → store loses 8 cycles, wins on the 9th. starve_cnt reads 0 after that grant.
- Store op 11 (AMO) granted → amo_busy_o=1 next cycle; ld/ptw rdy held 0 for 5 cycles. amo_done_i pulse → busy 0 next cycle and a pending load is granted in that cycle.
- Slot holds a store with l1d_req_rdy_i=0 for 3 cycles and a load waiting → outputs stable, ld_req_rdy_o=0. When rdy rises, the load is granted in that same cycle.
- rst asserted while slot valid and busy → next cycle all outputs 0, amo_busy_o=0. The first grant after reset follows normal priority.
